// File: rtl/irq_sequencer.sv
// Fixed-priority interrupt sequencer for the single-cycle CPU: it synchronizes 4 edge-triggered irq lines and, when it takes one, steers the datapath to that line's vector.
// Optional build macro IRQ_NESTING_EN lets a strictly higher-priority line preempt a running handler.
module irq_sequencer #(
    parameter logic [9:0] VEC_BASE    = 10'h3C0,
    parameter int         VEC_STRIDE  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_irq,
    input  logic       i_ei,
    input  logic       i_di,
    input  logic       i_reti,
    input  logic       i_hold,
    input  logic       i_mask_we,
    input  logic [3:0] i_mask_d,
    output logic       o_irq_take,
    output logic [9:0] o_irq_vector,
    output logic [1:0] o_active_id,
    output logic [3:0] o_pending,
    output logic [3:0] o_in_service,
    output logic       o_gie,
    output logic       o_spurious_reti
);

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0]                  r_syncPrev;
    logic [3:0]                  r_pending;
    logic [3:0]                  r_inService;
    logic [3:0]                  r_mask;
    logic                        r_gie;
    logic                        r_spurious;

    logic [3:0] w_edge;
    logic [3:0] w_eligible;
    logic [1:0] w_winner;
    logic [1:0] w_activeId;
    logic [3:0] w_winnerOneHot;
    logic [3:0] w_activeOneHot;
    logic       w_serviceOk;
    logic       w_take;

    // Bit 0 is highest priority, so the lowest set index wins.
    function automatic logic [1:0] lowestIndex(input logic [3:0] v);
        lowestIndex = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (v[k]) lowestIndex = 2'(k);
        end
    endfunction

    always_comb begin
        w_edge         = r_sync[SYNC_STAGES-1] & ~r_syncPrev;
        w_eligible     = r_pending & r_mask;
        w_winner       = lowestIndex(w_eligible);
        w_activeId     = lowestIndex(r_inService);
        w_winnerOneHot = 4'b0001 << w_winner;
        w_activeOneHot = 4'b0001 << w_activeId;
`ifdef IRQ_NESTING_EN
        w_serviceOk    = (r_inService == 4'b0000) || (w_winner < w_activeId);
`else
        w_serviceOk    = (r_inService == 4'b0000);
`endif
        w_take         = r_gie && (|w_eligible) && !i_hold && !i_reti && w_serviceOk;
    end

    // A new edge on the line being taken keeps it pending, so the clear is applied before the set.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync      <= '0;
            r_syncPrev  <= 4'b0000;
            r_pending   <= 4'b0000;
            r_inService <= 4'b0000;
            r_mask      <= 4'b0000;
            r_gie       <= 1'b0;
            r_spurious  <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_syncPrev <= r_sync[SYNC_STAGES-1];
            r_pending  <= (r_pending & ~(w_take ? w_winnerOneHot : 4'b0000)) | w_edge;

            if (w_take) begin
                r_inService <= r_inService | w_winnerOneHot;
            end else if (i_reti && (r_inService != 4'b0000)) begin
                r_inService <= r_inService & ~w_activeOneHot;
            end

            if (i_reti && (r_inService == 4'b0000)) begin
                r_spurious <= 1'b1;
            end

            if (i_di) begin
                r_gie <= 1'b0;
            end else if (i_ei) begin
                r_gie <= 1'b1;
            end

            if (i_mask_we) begin
                r_mask <= i_mask_d;
            end
        end
    end

    assign o_irq_take      = w_take;
    assign o_irq_vector    = VEC_BASE + (10'(VEC_STRIDE) * {8'd0, w_winner});
    assign o_active_id     = w_activeId;
    assign o_pending       = r_pending;
    assign o_in_service    = r_inService;
    assign o_gie           = r_gie;
    assign o_spurious_reti = r_spurious;

endmodule

// File: tb/tb_irq_sequencer.sv
// Randomized bench for irq_sequencer, checked against a behavioural model that applies the interrupt rules directly.
// Build with IRQ_NESTING_EN defined to exercise the preemption variant.
module tb_irq_sequencer;

    localparam int SYNC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] irq = 4'b0000;
    logic       ei = 1'b0, di = 1'b0, reti = 1'b0, hold = 1'b0, maskWe = 1'b0;
    logic [3:0] maskD = 4'b0000;
    logic       irqTake, gie, spuriousReti;
    logic [9:0] irqVector;
    logic [1:0] activeId;
    logic [3:0] pending, inService;

    irq_sequencer #(.VEC_BASE(10'h3C0), .VEC_STRIDE(4), .SYNC_STAGES(SYNC)) dut (
        .i_clk(clock), .i_reset(reset), .i_irq(irq), .i_ei(ei), .i_di(di),
        .i_reti(reti), .i_hold(hold), .i_mask_we(maskWe), .i_mask_d(maskD),
        .o_irq_take(irqTake), .o_irq_vector(irqVector), .o_active_id(activeId),
        .o_pending(pending), .o_in_service(inService), .o_gie(gie),
        .o_spurious_reti(spuriousReti)
    );

    always #5 clock = ~clock;

    int checkCount = 0;
    int failCount  = 0;

    // Model state: plain bit vectors plus a history of sampled irq values.
    bit [3:0] mPend, mInServ, mMask;
    bit       mGie, mSpur, modelValid;
    bit [3:0] mHist[$];

    // Values seen on the DUT during the most recent stimulus cycle.
    logic       lastTake, lastSpur;
    logic [9:0] lastVector;
    logic [3:0] lastPend, lastInServ;

    bit [3:0] irqState;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int lowestSet(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic applyStimulus(input bit rstIn, input bit [3:0] irqIn, input bit eiIn, input bit diIn,
                                 input bit retiIn, input bit holdIn, input bit mweIn, input bit [3:0] mdIn);
        int       win;
        int       act;
        bit       expTake;
        bit [3:0] edges;
        @(negedge clock);
        reset = rstIn; irq = irqIn; ei = eiIn; di = diIn;
        reti = retiIn; hold = holdIn; maskWe = mweIn; maskD = mdIn;
        #1;
        win = lowestSet(mPend & mMask);
        act = lowestSet(mInServ);
`ifdef IRQ_NESTING_EN
        expTake = mGie && win >= 0 && !holdIn && !retiIn && (act < 0 || win < act);
`else
        expTake = mGie && win >= 0 && !holdIn && !retiIn && (act < 0);
`endif
        if (modelValid) begin
            checkOutput("irq_take", irqTake, expTake);
            if (expTake) checkOutput("irq_vector", irqVector, (32'h3C0 + win * 4) % 1024);
            checkOutput("pending", pending, mPend);
            checkOutput("in_service", inService, mInServ);
            checkOutput("active_id", activeId, (act < 0) ? 0 : act);
            checkOutput("gie", gie, mGie);
            checkOutput("spurious_reti", spuriousReti, mSpur);
        end
        lastTake = irqTake; lastVector = irqVector; lastPend = pending;
        lastInServ = inService; lastSpur = spuriousReti;

        // Advance the model to the state after this clock edge.
        if (rstIn) begin
            mPend = 0; mInServ = 0; mMask = 0; mGie = 0; mSpur = 0; modelValid = 1;
            mHist.delete();
            for (int i = 0; i < SYNC + 2; i++) mHist.push_front(4'b0000);
        end else begin
            mHist.push_front(irqIn);
            void'(mHist.pop_back());
            edges = mHist[SYNC] & ~mHist[SYNC+1];
            if (expTake) begin
                mPend[win]   = 1'b0;
                mInServ[win] = 1'b1;
            end else if (retiIn && act >= 0) begin
                mInServ[act] = 1'b0;
            end
            mPend = mPend | edges;
            if (retiIn && act < 0) mSpur = 1'b1;
            if (diIn) mGie = 1'b0;
            else if (eiIn) mGie = 1'b1;
            if (mweIn) mMask = mdIn;
        end
        @(posedge clock);
    endtask

    initial begin
        for (int i = 0; i < SYNC + 2; i++) mHist.push_front(4'b0000);

        // Single irq[2] pulse: pending and take appear three clocks after the rise.
        applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
        applyStimulus(0, 4'b0000, 1, 0, 0, 0, 1, 4'hF);
        applyStimulus(0, 4'b0100, 0, 0, 0, 0, 0, 4'h0);
        applyStimulus(0, 4'b0100, 0, 0, 0, 0, 0, 4'h0);
        applyStimulus(0, 4'b0100, 0, 0, 0, 0, 0, 4'h0);
        checkOutput("tp_no_early_take", lastTake, 1'b0);
        applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
        checkOutput("tp_take", lastTake, 1'b1);
        checkOutput("tp_vector", lastVector, 10'h3C8);
        checkOutput("tp_pending_set", lastPend, 4'b0100);
        applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
        checkOutput("tp_take_one_cycle", lastTake, 1'b0);
        checkOutput("tp_in_service", lastInServ, 4'b0100);
        checkOutput("tp_pending_clear", lastPend, 4'b0000);

        // Legitimate reti, then a reti with nothing in service.
        applyStimulus(0, 4'b0000, 0, 0, 1, 0, 0, 4'h0);
        applyStimulus(0, 4'b0000, 0, 0, 1, 0, 0, 4'h0);
        applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
        checkOutput("tp_spurious_set", lastSpur, 1'b1);
        applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
        checkOutput("tp_spurious_sticky", lastSpur, 1'b1);
        applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
        applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
        checkOutput("tp_spurious_reset", lastSpur, 1'b0);

        // Random traffic, biased so interrupts are usually enabled and handlers return.
        irqState = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            bit rstR, eiR, diR, retiR, holdR, mweR;
            bit [3:0] mdR;
            for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) irqState[b] = ~irqState[b];
            rstR  = ($urandom_range(299) == 0);
            eiR   = ($urandom_range(5) == 0);
            diR   = ($urandom_range(29) == 0);
            retiR = (mInServ != 0) ? ($urandom_range(3) == 0) : ($urandom_range(59) == 0);
            holdR = ($urandom_range(3) == 0);
            mweR  = ($urandom_range(19) == 0);
            mdR   = ($urandom_range(2) == 0) ? 4'hF : 4'($urandom_range(15));
            applyStimulus(rstR, irqState, eiR, diR, retiR, holdR, mweR, mdR);
        end

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Interrupt controller for the single-cycle CPU datapath. Latches 4 external interrupt lines and arbitrates them by fixed priority.
- When an interrupt is taken, it sequences the datapath for one cycle: suppresses the fetched instruction, pushes the current PC on the hardware stack, and loads the PC with the vector address.
- Sits beside the control unit. Its outputs are ORed or muxed into the existing PC-source, stack-push and write-enable controls.

Parameters:
- VEC_BASE, 10'h3C0, PC address of the IRQ0 vector.
- VEC_STRIDE, 4, address distance between consecutive vectors.
- SYNC_STAGES, 2, synchronizer flop depth per irq line (min 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- irq  input  4  asynchronous interrupt requests, rising-edge sensitive; bit 0 highest priority
- ei  input  1  strobe from control unit: enable interrupts (global)
- di  input  1  strobe from control unit: disable interrupts (global)
- reti  input  1  strobe from control unit: current instruction is return-from-interrupt
- hold  input  1  current instruction uses the stack or PC (call/ret/jump); blocks a take this cycle
- mask_we  input  1  write strobe for the mask register
- mask_d  input  4  new mask value; 1 = line enabled
- irq_take  output  1  combinational; 1 in the cycle an interrupt is accepted
- irq_vector  output  10  PC load value, valid when irq_take=1
- active_id  output  2  index of the highest-priority in-service line
- pending  output  4  registered pending bits
- in_service  output  4  registered in-service bits
- gie  output  1  registered global interrupt enable
- spurious_reti  output  1  sticky error flag

Behaviour:
- Reset: all registers clear at a clk edge with reset=1. pending=0, in_service=0, mask=0, gie=0, spurious_reti=0, synchronizers=0, active_id=0.
- Synchronizer: each irq bit passes through SYNC_STAGES flops. edge[i] = sync[i] & ~sync_prev[i].
- An edge asserts pending[i] one cycle after the last sync stage. Total latency from an irq rise to pending=1 is SYNC_STAGES+1 clocks.
- Pending is set regardless of mask. A masked line stays pending.
- eligible = pending & mask. winner = lowest set index of eligible.
- Take condition, evaluated combinationally each cycle: gie & |eligible & ~hold & ~reti & (in_service==0).
- irq_take is combinational with zero latency. irq_vector = VEC_BASE + winner*VEC_STRIDE, computed modulo 2^10.
- When irq_take=1, the control unit must:
  - select the PC source as irq_vector;
  - assert the stack push, which pushes the current PC so the suppressed instruction re-executes after return;
  - force we3, wez, we4 and we_out low.
- Clock edge with irq_take=1: pending[winner] is cleared and in_service[winner] is set. If a new edge on the same line arrives in the same cycle, pending stays 1 (set dominates clear).
- reti clears the lowest-index set bit of in_service at the next edge. reti with in_service==0 sets spurious_reti, and it stays set until reset.
- ei/di update gie at the next edge. ei and di in the same cycle: di wins. A take in the same cycle as ei is not possible because gie is still old.
- gie is not altered by take or reti; in_service alone blocks further takes.
- mask_we writes mask at the edge. The new mask affects eligibility from the next cycle.
- active_id is the lowest set index of in_service, or 0 if none.
- Reset mid-service discards all pending and in-service state. The stack contents are not this block's concern.

Optional Feature:
- Macro: IRQ_NESTING_EN.
- Defined: the in_service==0 term of the take condition is replaced by "winner index < active_id, or in_service==0". A strictly higher-priority line preempts a running handler, and nesting is up to 4 deep. reti clears only the active_id bit, so lower-priority handlers resume in order.
- Undefined: no nesting, as specified above.

Test Plan:
- Reset, then ei, mask_d=4'hF with mask_we, pulse irq[2] -> pending[2]=1 after 3 clocks. irq_take=1 for exactly 1 cycle with irq_vector=10'h3C8. Then in_service=4'b0100 and pending=0.
- Assert irq[3] and irq[1] in the same cycle -> take selects line 1 (vector 10'h3C4). After reti, line 3 is taken (vector 10'h3CC) on the next eligible cycle.
- mask=4'b1110 and irq[0] edge -> pending[0]=1, no take. Write mask 4'hF -> take with vector 10'h3C0 the following cycle.
- Pending eligible while hold=1 for 3 cycles -> irq_take=0 throughout, asserts in the first cycle hold=0. With ei and di in the same cycle -> gie=0.
- reti with in_service=0 -> spurious_reti=1 and stays 1 until reset. Reset asserted while in_service=4'b0010 -> all state 0 next cycle.
- IRQ_NESTING_EN: handler for line 2 active, irq[0] edge -> take to 10'h3C0 and in_service=4'b0101. reti -> 4'b0100. Without the macro, no take until that reti.
